stopwatch_core: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 38 +++
 rtl/bcd_digit_counter.sv | 48 ++++
 rtl/stopwatch_core.sv | 213 +++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch engine: state encoding, BCD digit
// constants and the preset validation helper.
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 7;   // 2 frac + 2 seconds + 3 minutes
    localparam int MAX_BITS   = MAX_DIGITS * DIGIT_W;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True when every populated digit of a preset is a legal value for its
    // position: tens-of-seconds 0..5, every other digit 0..9.
    function automatic logic preset_valid(input logic [MAX_BITS-1:0] value,
                                          input int frac_digits,
                                          input int num_digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < num_digits) begin
                if (i == frac_digits + 1) begin
                    if (value[i*DIGIT_W +: DIGIT_W] > SEC_TENS_MAX) ok = 1'b0;
                end else begin
                    if (value[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time counter. Counts modulo MODULUS; carry/borrow are
// combinational so a whole chain of digits ripples within one clock.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               inc,
    input  logic               dec,
    output logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] value_next,
    output logic               carry,
    output logic               borrow
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MODULUS - 1);

    // Next digit value: clear beats load beats count.
    always_comb begin
        // NOTE: default assignment first so no path leaves value_next unassigned (no latch).
        value_next = value;
        if (clr) begin
            value_next = '0;
        end else if (load) begin
            value_next = load_val;
        end else if (inc) begin
            value_next = (value == LAST) ? '0 : value + DIGIT_W'(1);
        end else if (dec) begin
            value_next = (value == '0) ? LAST : value - DIGIT_W'(1);
        end
    end

    assign carry  = inc && (value == LAST);
    assign borrow = dec && (value == '0);

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) value <= '0;
        else     value <= value_next;
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/timer engine: prescaler, BCD time counter (frac/sec/min digits),
// up/down modes, preset load and lap hold.
// Optional feature: define STOPWATCH_LAP_EN to enable the lap hold register;
// without it the lap input is ignored and lap_hold is tied low.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int FRAC_DIGITS = 2,
    parameter int MIN_DIGITS  = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_pause,
    input  logic                                       clear,
    input  logic                                       lap,
    input  logic                                       dir_down,
    input  logic                                       load_valid,
    input  logic [DIGIT_W*(FRAC_DIGITS+2+MIN_DIGITS)-1:0] load_bcd,
    output logic [DIGIT_W*(FRAC_DIGITS+2+MIN_DIGITS)-1:0] bcd_out,
    output logic                                       running,
    output logic                                       lap_hold,
    output logic                                       expired,
    output logic                                       overflow,
    output logic                                       load_err
);

    localparam int NUM_DIGITS = FRAC_DIGITS + 2 + MIN_DIGITS;
    localparam int W          = DIGIT_W * NUM_DIGITS;
    localparam int TICK_HZ    = 10 ** FRAC_DIGITS;
    localparam int PRESCALE   = CLK_HZ / TICK_HZ;
    localparam int PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SEC_TENS   = FRAC_DIGITS + 1;

    localparam logic [PS_W-1:0] PRESCALE_LAST = PS_W'(PRESCALE - 1);

    if (FRAC_DIGITS < 0 || FRAC_DIGITS > 2) begin : g_bad_frac
        $error("stopwatch_core: FRAC_DIGITS must be 0..2");
    end
    if (MIN_DIGITS < 1 || MIN_DIGITS > 3) begin : g_bad_min
        $error("stopwatch_core: MIN_DIGITS must be 1..3");
    end
    if (CLK_HZ % TICK_HZ != 0 || PRESCALE < 1) begin : g_bad_prescale
        $error("stopwatch_core: CLK_HZ must be an exact multiple of 10**FRAC_DIGITS");
    end

    state_t          state;
    logic            dir_latched;
    logic [PS_W-1:0] prescale;

    logic [W-1:0]    live;
    logic [W-1:0]    live_next;
    logic [NUM_DIGITS:0] inc_chain;
    logic [NUM_DIGITS:0] dec_chain;

    logic tick;
    logic preset_ok;
    logic cnt_load;
    logic step_up;
    logic step_down;
    logic live_zero;
    logic live_one;
    logic reach_zero;
    logic borrow_top_unused;

    // Decode the counter controls for this cycle; clear suppresses everything else.
    always_comb begin
        tick       = (state == ST_RUN) && (prescale == PRESCALE_LAST);
        preset_ok  = preset_valid(MAX_BITS'(load_bcd), FRAC_DIGITS, NUM_DIGITS);
        live_zero  = (live == '0);
        live_one   = (live == W'(1));
        cnt_load   = !clear && (state == ST_IDLE) && load_valid && preset_ok;
        step_up    = !clear && tick && !dir_latched;
        // A zero preset in countdown finishes at the first tick without stepping.
        step_down  = !clear && tick && dir_latched && !live_zero;
        reach_zero = !clear && tick && dir_latched && (live_zero || live_one);
    end

    assign inc_chain[0]      = step_up;
    assign dec_chain[0]      = step_down;
    assign borrow_top_unused = dec_chain[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        localparam int MOD = (g == SEC_TENS) ? int'(SEC_TENS_MAX) + 1 : int'(DIGIT_MAX) + 1;

        bcd_digit_counter #(.MODULUS(MOD)) u_digit (
            .clk        (clk),
            .rst        (rst),
            .clr        (clear),
            .load       (cnt_load),
            .load_val   (load_bcd[g*DIGIT_W +: DIGIT_W]),
            .inc        (inc_chain[g]),
            .dec        (dec_chain[g]),
            .value      (live[g*DIGIT_W +: DIGIT_W]),
            .value_next (live_next[g*DIGIT_W +: DIGIT_W]),
            .carry      (inc_chain[g+1]),
            .borrow     (dec_chain[g+1])
        );
    end

    // Control FSM with registered status and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            dir_latched <= 1'b0;
            prescale    <= '0;
            running     <= 1'b0;
            expired     <= 1'b0;
            overflow    <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            expired  <= 1'b0;
            overflow <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                state    <= ST_IDLE;
                prescale <= '0;
                running  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_valid && !preset_ok) load_err <= 1'b1;
                        if (start_pause) begin
                            state       <= ST_RUN;
                            running     <= 1'b1;
                            dir_latched <= dir_down;
                            prescale    <= '0;
                        end
                    end
                    ST_RUN: begin
                        prescale <= tick ? '0 : prescale + PS_W'(1);
                        if (step_up && inc_chain[NUM_DIGITS]) overflow <= 1'b1;
                        // Reaching zero wins over a coincident pause.
                        if (reach_zero) begin
                            state   <= ST_DONE;
                            running <= 1'b0;
                            expired <= 1'b1;
                        end else if (start_pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start_pause) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        // Held at zero until clear.
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic [W-1:0] display_next;

`ifdef STOPWATCH_LAP_EN
    logic [W-1:0] hold;
    logic [W-1:0] hold_next;
    logic         lap_hold_next;
    logic         lap_act;

    // Lap toggle: capture the live value on the first press, release on the next.
    always_comb begin
        lap_act       = !clear && !start_pause && lap &&
                        ((state == ST_RUN) || (state == ST_PAUSE));
        hold_next     = hold;
        lap_hold_next = lap_hold;
        if (clear) begin
            lap_hold_next = 1'b0;
        end else if (lap_act) begin
            if (!lap_hold) begin
                hold_next     = live;
                lap_hold_next = 1'b1;
            end else begin
                lap_hold_next = 1'b0;
            end
        end
        display_next = lap_hold_next ? hold_next : live_next;
    end

    // Lap hold register and flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the hold register is a handful of flops, not a RAM, so it resets with everything else.
        if (rst) begin
            hold     <= '0;
            lap_hold <= 1'b0;
        end else begin
            hold     <= hold_next;
            lap_hold <= lap_hold_next;
        end
    end
`else
    logic lap_unused;

    assign lap_unused   = lap;
    assign lap_hold     = 1'b0;
    assign display_next = live_next;
`endif

    // Registered display value, updated in the same edge as the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bcd_out <= '0;
        else     bcd_out <= display_next;
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed, table-driven bench for stopwatch_core with CLK_HZ=1000 and
// FRAC_DIGITS=2 (prescale 10), MIN_DIGITS=2 (display mmssff in hex).
// Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_pause = 1'b0;
    logic         clear = 1'b0;
    logic         lap = 1'b0;
    logic         dir_down = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_bcd = '0;
    logic [W-1:0] bcd_out;
    logic         running;
    logic         lap_hold;
    logic         expired;
    logic         overflow;
    logic         load_err;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_core #(
        .CLK_HZ      (1000),
        .FRAC_DIGITS (2),
        .MIN_DIGITS  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_pause (start_pause),
        .clear       (clear),
        .lap         (lap),
        .dir_down    (dir_down),
        .load_valid  (load_valid),
        .load_bcd    (load_bcd),
        .bcd_out     (bcd_out),
        .running     (running),
        .lap_hold    (lap_hold),
        .expired     (expired),
        .overflow    (overflow),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sp, clr, lp, dn, ld;
        logic [W-1:0] ld_val;
        int           cycles;
        logic [W-1:0] exp_bcd;
        logic         exp_run, exp_lap;
        int           exp_expired, exp_ovf, exp_err;
    } vec_t;

    localparam int N_VEC   = 30;
    localparam int RST_ROW = 24;
    vec_t vecs[N_VEC];

    function automatic vec_t mk(input logic sp, clr, lp, dn, ld,
                                input logic [W-1:0] ldv, input int cyc,
                                input logic [W-1:0] eb, input logic er, el,
                                input int ee, eo, eerr);
        vec_t v;
        v.sp = sp; v.clr = clr; v.lp = lp; v.dn = dn; v.ld = ld;
        v.ld_val = ldv; v.cycles = cyc;
        v.exp_bcd = eb; v.exp_run = er; v.exp_lap = el;
        v.exp_expired = ee; v.exp_ovf = eo; v.exp_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one row for a single clock, then idle for v.cycles clocks while
    // counting pulses, then compare.
    task automatic apply(input int idx);
        vec_t v;
        int   n_exp, n_ovf, n_err;
        v = vecs[idx];
        n_exp = 0; n_ovf = 0; n_err = 0;
        @(negedge clk);
        start_pause = v.sp;
        clear       = v.clr;
        lap         = v.lp;
        dir_down    = v.dn;
        load_valid  = v.ld;
        load_bcd    = v.ld_val;
        @(posedge clk); #1;
        start_pause = 1'b0;
        clear       = 1'b0;
        lap         = 1'b0;
        dir_down    = 1'b0;
        load_valid  = 1'b0;
        load_bcd    = '0;
        n_exp += int'(expired); n_ovf += int'(overflow); n_err += int'(load_err);
        for (int c = 0; c < v.cycles; c++) begin
            @(posedge clk); #1;
            n_exp += int'(expired); n_ovf += int'(overflow); n_err += int'(load_err);
        end
        check($sformatf("v%0d bcd_out", idx),  32'(bcd_out),  32'(v.exp_bcd));
        check($sformatf("v%0d running", idx),  32'(running),  32'(v.exp_run));
        check($sformatf("v%0d lap_hold", idx), 32'(lap_hold), 32'(v.exp_lap));
        check($sformatf("v%0d expired_pulses", idx),  32'(n_exp), 32'(v.exp_expired));
        check($sformatf("v%0d overflow_pulses", idx), 32'(n_ovf), 32'(v.exp_ovf));
        check($sformatf("v%0d load_err_pulses", idx), 32'(n_err), 32'(v.exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bcd_out"},  32'(bcd_out),  32'd0);
        check({tag, " running"},  32'(running),  32'd0);
        check({tag, " lap_hold"}, 32'(lap_hold), 32'd0);
        check({tag, " expired"},  32'(expired),  32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " load_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        //                sp clr lp dn ld  load_val     cyc    exp_bcd      run lap      exp ovf err
        vecs[0]  = mk(0, 0, 0, 0, 0, 24'h000000,     2, 24'h000000,  0, 0,       0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 24'h000000, 60000, 24'h010000,  1, 0,       0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 24'h000000,     5, 24'h010000,  0, 0,       0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 24'h000000,     1, 24'h000000,  0, 0,       0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 24'h995999,     1, 24'h995999,  0, 0,       0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 24'h000000,    10, 24'h000000,  1, 0,       0, 1, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 24'h000000,     1, 24'h000000,  0, 0,       0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 24'h000005,     1, 24'h000005,  0, 0,       0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 1, 0, 24'h000000,    50, 24'h000000,  0, 0,       1, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 24'h000000,    20, 24'h000000,  0, 0,       0, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 0, 24'h000000,     1, 24'h000000,  0, 0,       0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 24'h000123,     0, 24'h000123,  0, 0,       0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, 24'h006000,     1, 24'h000123,  0, 0,       0, 0, 1);
        vecs[13] = mk(1, 0, 0, 0, 0, 24'h000000,     3, 24'h000123,  1, 0,       0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 24'h006000,     1, 24'h000123,  1, 0,       0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 1, 24'h000999,     1, 24'h000123,  1, 0,       0, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 0, 24'h000000,     0, 24'h000123,  1, LAP_EN,  0, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 24'h000000,   761, LAP_EN ? 24'h000123 : 24'h000200,
                                                                     1, LAP_EN,  0, 0, 0);
        vecs[18] = mk(0, 0, 1, 0, 0, 24'h000000,     0, 24'h000200,  1, 0,       0, 0, 0);
        vecs[19] = mk(0, 0, 1, 0, 0, 24'h000000,     2, 24'h000200,  1, LAP_EN,  0, 0, 0);
        vecs[20] = mk(1, 1, 1, 0, 0, 24'h000000,     0, 24'h000000,  0, 0,       0, 0, 0);
        vecs[21] = mk(1, 0, 0, 1, 0, 24'h000000,    10, 24'h000000,  0, 0,       1, 0, 0);
        vecs[22] = mk(0, 1, 0, 0, 0, 24'h000000,     0, 24'h000000,  0, 0,       0, 0, 0);
        vecs[23] = mk(1, 0, 0, 0, 0, 24'h000000,    25, 24'h000002,  1, 0,       0, 0, 0);
        // after the mid-run reset: partial interval survives a pause
        vecs[24] = mk(1, 0, 0, 0, 0, 24'h000000,     4, 24'h000000,  1, 0,       0, 0, 0);
        vecs[25] = mk(1, 0, 0, 0, 0, 24'h000000,     5, 24'h000000,  0, 0,       0, 0, 0);
        vecs[26] = mk(1, 0, 0, 0, 0, 24'h000000,     4, 24'h000000,  1, 0,       0, 0, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 24'h000000,     0, 24'h000001,  1, 0,       0, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 24'h000000,     8, 24'h000001,  1, 0,       0, 0, 0);
        // pause lands on a tick edge: the tick is still applied
        vecs[29] = mk(1, 0, 0, 0, 0, 24'h000000,     0, 24'h000002,  0, 0,       0, 0, 0);

        // Power-on reset, outputs must clear before any clock edge.
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            if (i == RST_ROW) begin
                // Asynchronous reset in the middle of RUN.
                @(negedge clk);
                #2 rst = 1'b1;
                #1 check_all_zero("midrun_reset");
                @(negedge clk);
                rst = 1'b0;
            end
            apply(i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
